// File: rtl/mul_byte_sequencer.sv
// Byte-serial front end for a 32x32 multiplier: assembles two 32-bit operands from
// a byte stream, runs the multiplier with a WAIT timeout, and streams the 64-bit product out.
module mul_byte_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic        din_valid,
    input  logic        dout_ready,
    output logic [7:0]  dout,
    output logic        dout_valid,
    output logic        busy,
    output logic        err,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_start,
    input  logic        mul_done,
    input  logic [63:0] mul_prod
);

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        START,
        WAIT,
        UNLOAD
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_idx;
    logic [2:0]  r_oidx;
    logic [7:0]  r_cnt;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;
    logic [63:0] r_prod;
    logic        r_err;

    logic        w_load_a;
    logic        w_load_b;
    logic        w_latch;
    logic        w_timeout;
    logic        w_accept;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= LOAD_A;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_load_a   = 1'b0;
        w_load_b   = 1'b0;
        w_latch    = 1'b0;
        w_timeout  = 1'b0;
        w_accept   = 1'b0;
        mul_start  = 1'b0;
        dout_valid = 1'b0;
        dout       = 8'h00;
        busy       = 1'b1;
        case (r_state)
            LOAD_A: begin
                busy = 1'b0;
                if (din_valid) begin
                    w_load_a = 1'b1;
                    if (r_idx == 2'd3) w_next = LOAD_B;
                end
            end
            LOAD_B: begin
                if (din_valid) begin
                    w_load_b = 1'b1;
                    if (r_idx == 2'd3) w_next = START;
                end
            end
            START: begin
                mul_start = 1'b1;
                w_next    = WAIT;
            end
            WAIT: begin
                // A done arriving on the last allowed cycle beats the timeout.
                if (mul_done) begin
                    w_latch = 1'b1;
                    w_next  = UNLOAD;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = LOAD_A;
                end
            end
            UNLOAD: begin
                dout_valid = 1'b1;
                dout       = r_prod[{r_oidx, 3'b000} +: 8];
                if (dout_ready) begin
                    w_accept = 1'b1;
                    if (r_oidx == 3'd7) w_next = LOAD_A;
                end
            end
            default: w_next = LOAD_A;
        endcase
    end

    // Byte indices wrap naturally: 3->0 hands LOAD_A over to LOAD_B, 7->0 ends UNLOAD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= 2'd0;
            r_oidx  <= 3'd0;
            r_cnt   <= 8'd0;
            r_mul_a <= 32'd0;
            r_mul_b <= 32'd0;
            r_prod  <= 64'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_load_a) r_mul_a[{r_idx, 3'b000} +: 8] <= din;
            if (w_load_b) r_mul_b[{r_idx, 3'b000} +: 8] <= din;
            if (w_load_a || w_load_b) r_idx <= r_idx + 2'd1;

            if (r_state == START || w_timeout)  r_cnt <= 8'd0;
            else if (r_state == WAIT && !mul_done) r_cnt <= r_cnt + 8'd1;

            if (w_latch) begin
                r_prod <= mul_prod;
                r_oidx <= 3'd0;
            end else if (w_accept) begin
                r_oidx <= r_oidx + 3'd1;
            end

            if (w_timeout) r_err <= 1'b1;
        end
    end

    assign mul_a = r_mul_a;
    assign mul_b = r_mul_b;
    assign err   = r_err;

endmodule
